// File: rtl/mux_nway_arb_if.sv
// Handshake/bus bundle for mux_nway_arb; in_last/out_last exist only when
// MUX_NWAY_ARB_LOCK_EN is defined.
interface mux_nway_arb_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
);
  // Valid/ready: a beat moves on a rising edge where valid && ready are both
  // high; ready is combinational here and may be high without valid.
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
`ifdef MUX_NWAY_ARB_LOCK_EN
  logic [N-1:0]       in_last;
  logic               out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_last
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
`endif
endinterface

// File: rtl/mux_nway_arb.sv
// Registered N-way mux with fixed-select or round-robin arbitration.
// Optional packet lock (in_last/out_last) under MUX_NWAY_ARB_LOCK_EN.
module mux_nway_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  mux_nway_arb_if.slave    bus,
  output logic [SELW-1:0]  dbg_rr_ptr
`ifdef MUX_NWAY_ARB_LOCK_EN
  ,
  output logic             dbg_locked
`endif
);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] g;
  logic [SELW-1:0] cand;
  logic [SELW-1:0] rr_next;
  logic            grant_valid;
  logic            space;
  logic            xfer_in;
  logic            advance;
  int              idx;

`ifdef MUX_NWAY_ARB_LOCK_EN
  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;
  lock_state_t     lock_state, lock_next;
  logic [SELW-1:0] lock_chan;
`endif

  assign space   = !bus.out_valid || bus.out_ready;
  assign xfer_in = grant_valid && space && bus.in_valid[g];
  assign rr_next = (int'(g) == N - 1) ? '0 : g + 1'b1;
  assign dbg_rr_ptr = rr_ptr;

  always_comb begin
    grant_valid = 1'b0;
    g           = '0;
    idx         = 0;
    cand        = '0;
    if (!mode) begin
      g           = sel;
      grant_valid = (int'(sel) < N);
    end
`ifdef MUX_NWAY_ARB_LOCK_EN
    else if (lock_state == ST_LOCKED) begin
      g           = lock_chan;
      grant_valid = 1'b1;
    end
`endif
    else begin
      // Scan backwards so the candidate closest to rr_ptr is written last.
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N) idx = idx - N;
        cand = SELW'(idx);
        if (bus.in_valid[cand]) begin
          g           = cand;
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (grant_valid && space) bus.in_ready[g] = 1'b1;
  end

`ifdef MUX_NWAY_ARB_LOCK_EN
  assign advance    = bus.in_last[g];
  assign dbg_locked = (lock_state == ST_LOCKED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_state <= ST_OPEN;
      lock_chan  <= '0;
    end else begin
      lock_state <= lock_next;
      if (xfer_in && mode) lock_chan <= g;
    end
  end

  always_comb begin
    lock_next = lock_state;
    if (!mode)        lock_next = ST_OPEN;
    else if (xfer_in) lock_next = bus.in_last[g] ? ST_OPEN : ST_LOCKED;
  end
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      rr_ptr        <= '0;
`ifdef MUX_NWAY_ARB_LOCK_EN
      bus.out_last  <= 1'b0;
`endif
    end else begin
      if (xfer_in) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.in_data[int'(g)*WIDTH +: WIDTH];
        bus.out_chan  <= g;
`ifdef MUX_NWAY_ARB_LOCK_EN
        bus.out_last  <= bus.in_last[g];
`endif
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (xfer_in && mode && advance) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_mux_nway_arb.sv
// Directed-vector bench for mux_nway_arb (N=4, WIDTH=32); exercises the lock
// path too when MUX_NWAY_ARB_LOCK_EN is defined.
module tb_mux_nway_arb;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic            clk;
  logic            reset_n;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [SELW-1:0] dbg_rr_ptr;
`ifdef MUX_NWAY_ARB_LOCK_EN
  logic            dbg_locked;
`endif

  int checks;
  int errors;

  mux_nway_arb_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();

  mux_nway_arb #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .sel        (sel),
    .bus        (bus.slave),
    .dbg_rr_ptr (dbg_rr_ptr)
`ifdef MUX_NWAY_ARB_LOCK_EN
    ,
    .dbg_locked (dbg_locked)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic            mode;
    logic [SELW-1:0] sel;
    logic [N-1:0]    in_valid;
    logic            out_ready;
    logic [N-1:0]    exp_ready;
    logic            exp_ov;
    logic [SELW-1:0] exp_chan;
    logic [SELW-1:0] exp_rr;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [WIDTH-1:0] chan_data(input logic [SELW-1:0] c);
    return 32'hA5A5_0000 | WIDTH'(c);
  endfunction

  function automatic vec_t mk(input logic m, input logic [SELW-1:0] s,
                              input logic [N-1:0] iv, input logic ordy,
                              input logic [N-1:0] er, input logic eov,
                              input logic [SELW-1:0] ech, input logic [SELW-1:0] err);
    vec_t v;
    v.mode = m; v.sel = s; v.in_valid = iv; v.out_ready = ordy;
    v.exp_ready = er; v.exp_ov = eov; v.exp_chan = ech; v.exp_rr = err;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // driver: apply inputs, check combinational ready, clock, check registers
  task automatic apply(input string tag, input vec_t v);
    mode          = v.mode;
    sel           = v.sel;
    bus.in_valid  = v.in_valid;
    bus.out_ready = v.out_ready;
    #1;
    chk({tag, " in_ready"}, WIDTH'(bus.in_ready), WIDTH'(v.exp_ready));
    @(posedge clk); #1;
    chk({tag, " out_valid"}, WIDTH'(bus.out_valid), WIDTH'(v.exp_ov));
    chk({tag, " out_chan"}, WIDTH'(bus.out_chan), WIDTH'(v.exp_chan));
    chk({tag, " out_data"}, bus.out_data, chan_data(v.exp_chan));
    chk({tag, " rr_ptr"}, WIDTH'(dbg_rr_ptr), WIDTH'(v.exp_rr));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    mode = 1'b0;
    sel = '0;
    bus.in_valid = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) bus.in_data[i*WIDTH +: WIDTH] = chan_data(SELW'(i));
`ifdef MUX_NWAY_ARB_LOCK_EN
    bus.in_last = '1;
`endif

    // fixed select, round-robin x8, backpressure, skip/wrap, fixed-mode corners
    vecs[0]  = mk(1'b0, 2'd2, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 2'd0);
    vecs[1]  = mk(1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 2'd1);
    vecs[2]  = mk(1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 2'd2);
    vecs[3]  = mk(1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 2'd3);
    vecs[4]  = mk(1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 2'd0);
    vecs[5]  = mk(1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 2'd1);
    vecs[6]  = mk(1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 2'd2);
    vecs[7]  = mk(1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 2'd3);
    vecs[8]  = mk(1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 2'd0);
    vecs[9]  = mk(1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 2'd0);
    vecs[10] = mk(1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 2'd0);
    vecs[11] = mk(1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 2'd0);
    vecs[12] = mk(1'b1, 2'd0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 2'd2);
    vecs[13] = mk(1'b1, 2'd0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 2'd3);
    vecs[14] = mk(1'b1, 2'd0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 2'd2);
    vecs[15] = mk(1'b1, 2'd0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd0, 2'd1);
    vecs[16] = mk(1'b0, 2'd1, 4'h0, 1'b1, 4'h2, 1'b0, 2'd0, 2'd1);
    vecs[17] = mk(1'b0, 2'd3, 4'h8, 1'b0, 4'h8, 1'b1, 2'd3, 2'd1);
    vecs[18] = mk(1'b0, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 2'd1);
    vecs[19] = mk(1'b1, 2'd0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd3, 2'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", WIDTH'(bus.out_valid), 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset out_chan", WIDTH'(bus.out_chan), 0);
    chk("reset rr_ptr", WIDTH'(dbg_rr_ptr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) apply($sformatf("v%0d", i), vecs[i]);

    // async reset mid-stream with a held beat and rr_ptr=1
    apply("pre_rst", mk(1'b0, 2'd2, 4'hF, 1'b0, 4'h1 << 2, 1'b1, 2'd2, 2'd1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst out_valid", WIDTH'(bus.out_valid), 0);
    chk("async_rst out_data", bus.out_data, 0);
    chk("async_rst out_chan", WIDTH'(bus.out_chan), 0);
    chk("async_rst rr_ptr", WIDTH'(dbg_rr_ptr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    apply("post_rst", mk(1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 2'd1));

`ifdef MUX_NWAY_ARB_LOCK_EN
    begin
      logic [N-1:0] lk_last[4];
      logic [N-1:0] lk_valid[4];
      logic [N-1:0] lk_ready[4];
      logic [SELW-1:0] lk_chan[4];
      logic [SELW-1:0] lk_rr[4];
      lk_last  = '{4'h0, 4'h0, 4'h4, 4'h8};
      lk_valid = '{4'hC, 4'hC, 4'hC, 4'h8};
      lk_ready = '{4'h4, 4'h4, 4'h4, 4'h8};
      lk_chan  = '{2'd2, 2'd2, 2'd2, 2'd3};
      lk_rr    = '{2'd1, 2'd1, 2'd3, 2'd0};
      for (int i = 0; i < 4; i++) begin
        bus.in_last = lk_last[i];
        apply($sformatf("lock%0d", i),
              mk(1'b1, 2'd0, lk_valid[i], 1'b1, lk_ready[i], 1'b1, lk_chan[i], lk_rr[i]));
      end
      bus.in_last = '1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nway_arb.md
Name: mux_nway_arb

Overview:
Parametrised, registered N-way WIDTH-bit multiplexer with per-channel valid/ready handshake. Generalises the combinational bit-level mux tree into a sequential stage.
- Fixed-select mode: channel chosen by `sel`.
- Round-robin mode: fair arbitration among requesting channels.

Used wherever several datapath producers (e.g. writeback sources, memory ports) share one consumer.

Parameters:
- WIDTH, 32, data bits per channel.
- N, 4, number of input channels (2..16).
- SELW, 2, channel index width; must equal clog2(N).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = fixed select via sel; 1 = round-robin
- sel  in  SELW  channel index used when mode=0
- in_valid  in  N  per-channel request; bit i belongs to channel i
- in_ready  out  N  per-channel accept; combinational
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts the beat
- out_data  out  WIDTH  registered data
- out_chan  out  SELW  index of the channel that supplied out_data

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr_ptr=0, lock state cleared. Reset asserted mid-transfer discards the held beat immediately.
- Single-entry output register. space = !out_valid || out_ready.
- Grant g (combinational):
  - mode=0: g=sel, valid only if sel<N.
  - mode=1: first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
  - No grant if no eligible request.
- in_ready[i] = grant_valid && (i==g) && space. At most one bit of in_ready is set. in_ready never depends on in_valid[i] of other channels in mode=0.
- Transfer in: in_valid[g] && in_ready[g]. On the next edge: out_data <= channel g data, out_chan <= g, out_valid <= 1.
- Transfer out: out_valid && out_ready. If there is no simultaneous transfer in, out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous in/out transfer in the same cycle: the register reloads. Sustained throughput is 1 beat/cycle. Input-to-output latency is 1 cycle.
- Holding (out_valid=1, out_ready=0): out_data and out_chan are stable, all in_ready=0.
- rr_ptr updates only on a mode=1 transfer in: rr_ptr <= (g+1) mod N, wrapping from N-1 to 0. In mode=0, rr_ptr is unchanged.
- sel>=N (possible when N is not a power of 2): no grant, all in_ready=0, no error flag.
- A mode or sel change takes effect in the same cycle's arbitration. A beat already held is unaffected.
- in_valid dropping without a handshake is permitted; the block does not police producer protocol.

Optional Feature:
- Macro: MUX_NWAY_ARB_LOCK_EN.
- With the macro defined:
  - Adds port `in_last`, input, N bits, end-of-packet marker per channel.
  - In mode=1, a transfer in with in_last[g]=0 locks the grant to g. Other channels get in_ready=0 until a beat from g transfers with in_last[g]=1.
  - rr_ptr advances only on that last beat.
  - Lock is cleared by reset and by mode=0.
  - out_last (output, 1 bit) is registered alongside out_data; reset value 0.
- Without the macro: no in_last or out_last ports, and re-arbitration happens on every beat.

Test Plan:
- Reset: assert reset_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately, with no clock edge needed. After release, the first round-robin grant goes to channel 0.
- Fixed mode: mode=0, sel=2, all in_valid=1, channel 2 data=0xA5A5_0002, out_ready=1 -> only in_ready[2]=1. Next cycle out_data=0xA5A5_0002, out_chan=2.
- Round-robin fairness: mode=1, all four in_valid=1 held for 8 cycles, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> all in_ready=0 and out_data stable. Raise out_ready with in_valid[1]=1 -> drain and reload happen in the same cycle, so out_valid stays 1 and out_chan=1.
- Skip and wrap: mode=1, rr_ptr=3, only in_valid[1]=1 -> grant 1, then rr_ptr=2. Next, only in_valid[0]=1 -> grant 0 after wrapping from 3.
- Lock (MUX_NWAY_ARB_LOCK_EN): channel 2 sends 3 beats with in_last=0,0,1 while channel 3 is valid throughout -> out_chan=2,2,2 then 3; in_ready[3]=0 during the packet.
